fib_seq_gen: RTL and testbench

- Parametrised Fibonacci-style sequence generator.
- Successor to the fixed 16-bit free-running generator. Adds:
  - configurable width and seeds;
  - runtime seed load;
  - a bounded term count per run;
  - valid/ready output handshake;
  - overflow detection with selectable wrap or stop policy.
- Sits as a stream source feeding downstream datapath or test logic.

---
 rtl/fib_seq_gen.sv | 123 ++++++++++++
 tb/tb_fib_seq_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_gen.sv
// Fibonacci-style stream source: loadable seeds, bounded run length, valid/ready
// output, and overflow tracking with either wrap-and-flag or stop-before-overflow.
module fib_seq_gen #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [WIDTH-1:0] SEED0       = '0,
  parameter logic [WIDTH-1:0] SEED1       = WIDTH'(1),
  parameter bit               STOP_ON_OVF = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             use_seed_in,
  input  logic [WIDTH-1:0] seed0_in,
  input  logic [WIDTH-1:0] seed1_in,
  input  logic             abort,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_ovf,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             a_ovf_q, a_ovf_d;
  logic             b_ovf_q, b_ovf_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;

  logic             run;
  logic             accept;
  logic             last;
  logic [WIDTH:0]   sum;

  assign run    = (state_q == RUN);
  assign accept = run && out_ready;
  assign sum    = {1'b0, a_q} + {1'b0, b_q};

  // b holds the next term, so a pending overflow in b means a is the last clean one.
  assign last = run && ((remaining_q == CNT_W'(1)) || (STOP_ON_OVF && b_ovf_q));

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    a_ovf_d     = a_ovf_q;
    b_ovf_d     = b_ovf_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (n_terms != '0)) begin
          state_d     = RUN;
          a_d         = use_seed_in ? seed0_in : SEED0;
          b_d         = use_seed_in ? seed1_in : SEED1;
          a_ovf_d     = 1'b0;
          b_ovf_d     = 1'b0;
          remaining_d = n_terms;
        end
      end

      RUN: begin
        if (accept) begin
          a_d         = b_q;
          a_ovf_d     = b_ovf_q;
          b_d         = sum[WIDTH-1:0];
          b_ovf_d     = sum[WIDTH] | a_ovf_q | b_ovf_q;
          remaining_d = remaining_q - CNT_W'(1);
        end
        // Abort wins over a simultaneous final handshake and suppresses done.
        if (abort) begin
          state_d = IDLE;
        end else if (accept && last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      a_ovf_q     <= 1'b0;
      b_ovf_q     <= 1'b0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values together.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_ovf_q     <= a_ovf_d;
      b_ovf_q     <= b_ovf_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = run ? a_q : '0;
  assign out_valid = run;
  assign out_last  = last;
  assign out_ovf   = run & a_ovf_q;
  assign busy      = run;
  assign done      = done_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Three generator instances (16-bit wrap, 8-bit wrap, 8-bit stop) share one stimulus
// stream; a per-instance scoreboard is filled from an arithmetic model of the sequence.
module tb_fib_seq_gen;

  logic             clk;
  logic             rst;
  logic             start;
  logic [7:0]       n_terms;
  logic             use_seed_in;
  logic [15:0]      seed0_in;
  logic [15:0]      seed1_in;
  logic             abort;
  logic             out_ready;

  logic [2:0][15:0] o_data;
  logic [2:0]       o_valid;
  logic [2:0]       o_last;
  logic [2:0]       o_ovf;
  logic [2:0]       o_busy;
  logic [2:0]       o_done;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 16 : 8;
    localparam bit          S = (g == 2);
    logic [W-1:0] data;

    fib_seq_gen #(
      .WIDTH      (W),
      .CNT_W      (8),
      .STOP_ON_OVF(S)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .n_terms    (n_terms),
      .use_seed_in(use_seed_in),
      .seed0_in   (seed0_in[W-1:0]),
      .seed1_in   (seed1_in[W-1:0]),
      .abort      (abort),
      .out_data   (data),
      .out_valid  (o_valid[g]),
      .out_ready  (out_ready),
      .out_last   (o_last[g]),
      .out_ovf    (o_ovf[g]),
      .busy       (o_busy[g]),
      .done       (o_done[g])
    );

    assign o_data[g] = 16'(data);
  end

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t exp_q [3][$];

  int n_checks = 0;
  int n_fails  = 0;
  int hs_cnt [3];
  int done_cnt = 0;
  int mode     = 0;
  int pat      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int dut_width(input int d);
    return (d == 0) ? 16 : 8;
  endfunction

  // Exact integer Fibonacci values; a term is flagged once its true value no longer fits.
  function automatic void build(input int d, input logic [15:0] s0, input logic [15:0] s1,
                                input int n);
    longint unsigned lim = 64'd1 << dut_width(d);
    longint unsigned t0  = 64'(s0) % lim;
    longint unsigned t1  = 64'(s1) % lim;
    longint unsigned nx;
    bit              stop = (d == 2);
    exp_t            e;
    for (int k = 0; k < n; k++) begin
      e.data = 16'(t0 % lim);
      e.ovf  = (t0 >= lim);
      e.last = (k == n - 1) || (stop && (t1 >= lim));
      exp_q[d].push_back(e);
      if (e.last) break;
      nx = t0 + t1;
      t0 = t1;
      t1 = nx;
    end
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
          pat++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability, and done timing.
  bit          prev_stall   [3];
  bit          prev_last_hs [3];
  logic [15:0] prev_data    [3];
  logic        prev_last    [3];
  logic        prev_ovf     [3];
  bit          prev_abort = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   exp_done;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        prev_stall[d]   = 0;
        prev_last_hs[d] = 0;
      end else begin
        if (prev_stall[d]) begin
          if (o_valid[d]) begin
            check($sformatf("dut%0d stall_data", d), o_data[d], prev_data[d]);
            check($sformatf("dut%0d stall_last", d), o_last[d], prev_last[d]);
            check($sformatf("dut%0d stall_ovf", d), o_ovf[d], prev_ovf[d]);
          end else if (!prev_abort) begin
            check($sformatf("dut%0d valid_drop", d), 0, 1);
          end
        end
        exp_done = prev_last_hs[d] && !prev_abort;
        if (o_done[d] || exp_done) check($sformatf("dut%0d done", d), o_done[d], exp_done);
        if (o_done[d]) done_cnt++;

        prev_last_hs[d] = 0;
        prev_stall[d]   = o_valid[d] && !out_ready;
        prev_data[d]    = o_data[d];
        prev_last[d]    = o_last[d];
        prev_ovf[d]     = o_ovf[d];

        if (o_valid[d] && out_ready) begin
          hs_cnt[d]++;
          if (exp_q[d].size() == 0) begin
            check($sformatf("dut%0d unexpected_term", d), 1, 0);
          end else begin
            e = exp_q[d].pop_front();
            check($sformatf("dut%0d data", d), o_data[d], e.data);
            check($sformatf("dut%0d last", d), o_last[d], e.last);
            check($sformatf("dut%0d ovf", d), o_ovf[d], e.ovf);
          end
          prev_last_hs[d] = o_last[d];
        end
      end
    end
    prev_abort = abort;
  end

  task automatic wait_idle();
    int cyc = 0;
    while ((o_busy != 3'b000) && (cyc < 5000)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 5000) check("idle_timeout", 0, 1);
  endtask

  task automatic flush_all();
    for (int d = 0; d < 3; d++) exp_q[d].delete();
  endtask

  task automatic run(input bit us, input logic [15:0] s0, input logic [15:0] s1, input int n,
                     input int abort_at, input int rst_at, input bit poke);
    int base;
    int done_base;
    int tgt;
    int cyc;
    wait_idle();
    use_seed_in = us;
    seed0_in    = s0;
    seed1_in    = s1;
    n_terms     = 8'(n);
    start       = 1'b1;
    if (n != 0) for (int d = 0; d < 3; d++) build(d, us ? s0 : 16'd0, us ? s1 : 16'd1, n);
    base      = hs_cnt[0];
    done_base = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;

    if (n == 0) begin
      check("zero_n busy", 32'(o_busy), 0);
      repeat (3) @(posedge clk);
      #1;
      check("zero_n done", done_cnt, done_base);
      return;
    end

    if (poke) begin
      start   = 1'b1;
      n_terms = 8'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
    end

    if ((abort_at >= 0) || (rst_at >= 0)) begin
      tgt = (abort_at >= 0) ? abort_at : rst_at;
      cyc = 0;
      while (((hs_cnt[0] - base) < tgt) && (cyc < 1000)) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      check("reach_target", 32'(cyc < 1000), 1);
      if (abort_at >= 0) begin
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort busy", 32'(o_busy), 0);
        check("abort valid", 32'(o_valid), 0);
      end else begin
        rst = 1'b1;
        #1;
        check("rst busy", 32'(o_busy), 0);
        check("rst valid", 32'(o_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      flush_all();
      repeat (2) @(posedge clk);
      #1;
      check("interrupted done", done_cnt, done_base);
    end else begin
      wait_idle();
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) check($sformatf("dut%0d drained", d), exp_q[d].size(), 0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    n_terms     = '0;
    use_seed_in = 1'b0;
    seed0_in    = '0;
    seed1_in    = '0;
    abort       = 1'b0;
    #3;
    for (int d = 0; d < 3; d++) check($sformatf("dut%0d reset data", d), o_data[d], 0);
    check("reset valid", 32'(o_valid), 0);
    check("reset last", 32'(o_last), 0);
    check("reset ovf", 32'(o_ovf), 0);
    check("reset busy", 32'(o_busy), 0);
    check("reset done", 32'(o_done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    mode = 0; run(1'b0, 16'd0, 16'd0, 10, -1, -1, 1'b0);
    mode = 1; run(1'b0, 16'd0, 16'd0, 10, -1, -1, 1'b0);
    mode = 0; run(1'b0, 16'd0, 16'd0, 16, -1, -1, 1'b0);
    run(1'b0, 16'd0, 16'd0, 20, -1, -1, 1'b0);
    run(1'b1, 16'd2, 16'd1, 5, -1, -1, 1'b0);
    run(1'b0, 16'd0, 16'd0, 0, -1, -1, 1'b0);
    mode = 1; run(1'b0, 16'd0, 16'd0, 10, 2, -1, 1'b0);
    mode = 2; run(1'b0, 16'd0, 16'd0, 10, -1, 4, 1'b0);
    mode = 0; run(1'b0, 16'd0, 16'd0, 10, -1, -1, 1'b0);

    for (int i = 0; i < 25; i++) begin
      mode = int'($urandom_range(0, 2));
      run(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
          16'($urandom_range(0, 65535)), int'($urandom_range(1, 60)), -1, -1, 1'b1);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
